// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rv32_pkg
// Brief   : Shared RV32I widths and the write-back request record.
// Revision: 1.0 - initial release
// ============================================================================
package rv32_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module  : wb_fifo
// Brief   : Load-completion FIFO with per-entry live bits and rd-based squash.
// Revision: 1.0 - initial release
// ============================================================================
module wb_fifo
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_en,
    input  wb_req_t           push_req,
    input  logic              push_live,
    input  logic              pop_en,
    input  logic              squash_en,
    input  logic [REG_AW-1:0] squash_rd,
    output logic              full,
    output logic              empty,
    output wb_req_t           head_req,
    output logic              head_live,
    output logic [REG_AW-1:0] ent_rd [DEPTH],
    output logic [DEPTH-1:0]  ent_live
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    // Pointers carry an extra MSB so full and empty differ on wrap.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    wb_req_t          mem_q [DEPTH];
    wb_req_t          mem_d [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [AW:0]      count;

    assign count     = wr_ptr_q - rd_ptr_q;
    assign full      = (count == DEPTH_CNT);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign head_req  = mem_q[rd_ptr_q[AW-1:0]];
    assign head_live = live_q[rd_ptr_q[AW-1:0]];

    // An entry counts for busy only while it sits inside the occupied window.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [AW-1:0] off;
        assign off         = AW'(i) - rd_ptr_q[AW-1:0];
        assign ent_rd[i]   = mem_q[i].rd;
        assign ent_live[i] = live_q[i] && ({1'b0, off} < count);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        live_d   = live_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (squash_en && (mem_q[i].rd == squash_rd)) begin
                live_d[i] = 1'b0;
            end
        end
        if (push_en) begin
            mem_d[wr_ptr_q[AW-1:0]]  = push_req;
            live_d[wr_ptr_q[AW-1:0]] = push_live;
            wr_ptr_d                 = wr_ptr_q + 1'b1;
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            live_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            live_q   <= live_d;
            mem_q    <= mem_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : wb_arbiter
// Brief   : Merges ALU results and queued loads onto the register-file port.
// Revision: 1.0 - initial release
// ============================================================================
module wb_arbiter
    import rv32_pkg::*;
#(
    parameter int LD_DEPTH   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    output logic              alu_stall,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [REG_AW-1:0] ld_rd,
    input  logic [XLEN-1:0]   ld_data,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic              busy_rs1,
    output logic              busy_rs2,
    output logic              RegWrite,
    output logic [REG_AW-1:0] WriteRegister,
    output logic [XLEN-1:0]   WriteData
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_CAP = SW'(STARVE_MAX);

    logic              fifo_full, fifo_empty;
    wb_req_t           head_req;
    logic              head_live;
    logic [REG_AW-1:0] ent_rd [LD_DEPTH];
    logic [LD_DEPTH-1:0] ent_live;

    logic              force_head, alu_win, fifo_win, push_en, push_live;
    logic [SW-1:0]     starve_q, starve_d;
    logic              regwrite_q, regwrite_d;
    logic [REG_AW-1:0] wreg_q, wreg_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;

    assign ld_ready   = !fifo_full;
    assign force_head = !fifo_empty && (starve_q == STARVE_CAP);
    assign alu_win    = alu_valid && !force_head;
    assign fifo_win   = !fifo_empty && !alu_win;
    assign alu_stall  = force_head;
    assign push_en    = ld_valid && ld_ready && (ld_rd != '0);
    // A load arriving alongside a same-rd ALU write is older, so it lands dead.
    assign push_live  = !(alu_win && (alu_rd == ld_rd));

    wb_fifo #(
        .DEPTH(LD_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_en  (push_en),
        .push_req ({ld_rd, ld_data}),
        .push_live(push_live),
        .pop_en   (fifo_win),
        .squash_en(alu_win),
        .squash_rd(alu_rd),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_req (head_req),
        .head_live(head_live),
        .ent_rd   (ent_rd),
        .ent_live (ent_live)
    );

    always_comb begin
        regwrite_d = 1'b0;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        starve_d   = starve_q;
        if (alu_win) begin
            regwrite_d = (alu_rd != '0);
            wreg_d     = alu_rd;
            wdata_d    = alu_data;
        end else if (fifo_win) begin
            regwrite_d = head_live && (head_req.rd != '0);
            wreg_d     = head_req.rd;
            wdata_d    = head_req.data;
        end
        if (fifo_empty || fifo_win) begin
            starve_d = '0;
        end else if (alu_win && (starve_q != STARVE_CAP)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        busy_rs1 = 1'b0;
        busy_rs2 = 1'b0;
        for (int i = 0; i < LD_DEPTH; i++) begin
            if (ent_live[i] && (ent_rd[i] == rs1)) busy_rs1 = 1'b1;
            if (ent_live[i] && (ent_rd[i] == rs2)) busy_rs2 = 1'b1;
        end
        if (regwrite_q && (wreg_q == rs1)) busy_rs1 = 1'b1;
        if (regwrite_q && (wreg_q == rs2)) busy_rs2 = 1'b1;
        if (rs1 == '0) busy_rs1 = 1'b0;
        if (rs2 == '0) busy_rs2 = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q   <= '0;
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
        end else begin
            starve_q   <= starve_d;
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
        end
    end

    assign RegWrite      = regwrite_q;
    assign WriteRegister = wreg_q;
    assign WriteData     = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_arbiter
// Brief   : Directed and random stimulus against a queue-based write-back model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int LD_DEPTH   = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_stall, ld_valid, ld_ready;
    logic [4:0]  alu_rd, ld_rd, rs1, rs2, WriteRegister;
    logic [31:0] alu_data, ld_data, WriteData;
    logic        busy_rs1, busy_rs2, RegWrite;

    always #5 clk = ~clk;

    wb_arbiter #(
        .LD_DEPTH  (LD_DEPTH),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .alu_stall    (alu_stall),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_rd        (ld_rd),
        .ld_data      (ld_data),
        .rs1          (rs1),
        .rs2          (rs2),
        .busy_rs1     (busy_rs1),
        .busy_rs2     (busy_rs2),
        .RegWrite     (RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          live;
    } ent_t;

    ent_t        mq[$];
    int          m_starve;
    bit          m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    bit          m_last_stall;
    bit          m_last_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_busy(input logic [4:0] rs);
        if (rs == 5'd0) return 1'b0;
        if (m_we && (m_reg == rs)) return 1'b1;
        foreach (mq[i]) if (mq[i].live && (mq[i].rd == rs)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_starve     = 0;
        m_we         = 1'b0;
        m_reg        = '0;
        m_data       = '0;
        m_last_stall = 1'b0;
        m_last_ready = 1'b1;
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ldd,
                         input logic [4:0] r1, input logic [4:0] r2);
        alu_valid = av;  alu_rd = ard;  alu_data = ad;
        ld_valid  = lv;  ld_rd  = lrd;  ld_data  = ldd;
        rs1 = r1;  rs2 = r2;
    endtask

    // Inputs are already applied; check the combinational view, advance the
    // model by one cycle's rules, clock, then check the write port.
    task automatic step();
        bit   hv, rdy, frc, aw, popd;
        ent_t e;
        #1;
        hv  = (mq.size() > 0);
        rdy = (mq.size() < LD_DEPTH);
        frc = hv && (m_starve == STARVE_MAX);
        chk("ld_ready", ld_ready, rdy);
        chk("alu_stall", alu_stall, frc);
        chk("busy_rs1", busy_rs1, m_busy(rs1));
        chk("busy_rs2", busy_rs2, m_busy(rs2));
        aw   = alu_valid && !frc;
        popd = 1'b0;
        if (aw) begin
            m_we   = (alu_rd != 5'd0);
            m_reg  = alu_rd;
            m_data = alu_data;
            foreach (mq[i]) if (mq[i].rd == alu_rd) mq[i].live = 1'b0;
        end else if (hv) begin
            e      = mq.pop_front();
            popd   = 1'b1;
            m_we   = e.live && (e.rd != 5'd0);
            m_reg  = e.rd;
            m_data = e.data;
        end else begin
            m_we = 1'b0;
        end
        if (!hv || popd) m_starve = 0;
        else if (aw && m_starve < STARVE_MAX) m_starve++;
        if (ld_valid && rdy && (ld_rd != 5'd0)) begin
            e.rd   = ld_rd;
            e.data = ld_data;
            e.live = !(aw && (alu_rd == ld_rd));
            mq.push_back(e);
        end
        m_last_stall = frc;
        m_last_ready = rdy;
        @(posedge clk);
        #1;
        chk("RegWrite", RegWrite, m_we);
        if (m_we) begin
            chk("WriteRegister", WriteRegister, m_reg);
            chk("WriteData", WriteData, m_data);
        end
    endtask

    task automatic cyc(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldd,
                       input logic [4:0] r1, input logic [4:0] r2);
        drive(av, ard, ad, lv, lrd, ldd, r1, r2);
        step();
    endtask

    task automatic random_cycles(input int n);
        logic       av, lv;
        logic [4:0] ard, lrd;
        logic [31:0] ad, ldd;
        for (int k = 0; k < n; k++) begin
            av = alu_valid; ard = alu_rd; ad = alu_data;
            lv = ld_valid;  lrd = ld_rd;  ldd = ld_data;
            if (!(m_last_stall && alu_valid)) begin
                av  = ($urandom_range(0, 99) < 55);
                ard = 5'($urandom_range(0, 7));
                ad  = $urandom;
            end
            if (!(ld_valid && !m_last_ready)) begin
                lv  = ($urandom_range(0, 99) < 50);
                lrd = 5'($urandom_range(0, 7));
                ldd = $urandom;
            end
            cyc(av, ard, ad, lv, lrd, ldd, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
    endtask

    initial begin
        model_reset();
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hA5A5_A5A5, 5'd5, 5'd5);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_RegWrite", RegWrite, 1'b0);
        chk("rst_WriteRegister", WriteRegister, 5'd0);
        chk("rst_WriteData", WriteData, 32'd0);
        chk("rst_ld_ready", ld_ready, 1'b1);
        chk("rst_alu_stall", alu_stall, 1'b0);
        chk("rst_busy", {busy_rs1, busy_rs2}, 2'b00);
        @(negedge clk);
        ld_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;

        // Load alone: enqueued, then written on the following edge.
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hA5A5_A5A5, 5'd0, 5'd0);
        chk("lit_ld_enq_no_write", RegWrite, 1'b0);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        chk("lit_ld_write", {RegWrite, WriteRegister, WriteData}, {1'b1, 5'd5, 32'hA5A5_A5A5});
        chk("lit_model_ld", m_data, 32'hA5A5_A5A5);

        // Both sources together: ALU first, load next.
        cyc(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 5'd0, 5'd4);
        chk("lit_both_alu", {RegWrite, WriteRegister, WriteData}, {1'b1, 5'd3, 32'h11});
        chk("lit_busy_queued", busy_rs2, 1'b1);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd4);
        chk("lit_both_ld", {RegWrite, WriteRegister, WriteData}, {1'b1, 5'd4, 32'h22});
        chk("lit_busy_outstage", busy_rs2, 1'b1);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd4);
        chk("lit_busy_clear", {RegWrite, busy_rs2}, 2'b00);

        // WAW squash of a queued load.
        cyc(1'b1, 5'd1, 32'h100, 1'b1, 5'd7, 32'hDEAD, 5'd7, 5'd0);
        chk("lit_waw_busy", busy_rs1, 1'b1);
        cyc(1'b1, 5'd7, 32'hBEEF, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
        chk("lit_waw_alu", {RegWrite, WriteRegister, WriteData}, {1'b1, 5'd7, 32'hBEEF});
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
        chk("lit_waw_dead_drain", {RegWrite, busy_rs1}, 2'b00);

        // Starvation: four ALU wins, then the load is forced through.
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 5'd0, 5'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 5'(10 + k), 32'h1000 + k, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
            chk("lit_starve_alu", WriteRegister, 5'(10 + k));
        end
        drive(1'b1, 5'd14, 32'h1004, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        #1;
        chk("lit_starve_stall", alu_stall, 1'b1);
        step();
        chk("lit_starve_ld", {RegWrite, WriteRegister, WriteData}, {1'b1, 5'd9, 32'h99});
        cyc(1'b1, 5'd14, 32'h1004, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        chk("lit_starve_held", {RegWrite, WriteRegister, WriteData}, {1'b1, 5'd14, 32'h1004});

        // Full FIFO: third load refused, first two drain in order.
        cyc(1'b1, 5'd1, 32'h200, 1'b1, 5'd2, 32'h300, 5'd0, 5'd0);
        cyc(1'b1, 5'd1, 32'h201, 1'b1, 5'd3, 32'h301, 5'd0, 5'd0);
        chk("lit_full_ready", ld_ready, 1'b0);
        cyc(1'b1, 5'd1, 32'h202, 1'b1, 5'd6, 32'h302, 5'd0, 5'd0);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        chk("lit_full_first", {WriteRegister, WriteData}, {5'd2, 32'h300});
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        chk("lit_full_second", {WriteRegister, WriteData}, {5'd3, 32'h301});
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        chk("lit_full_nothing_more", RegWrite, 1'b0);

        // x0 targets never write.
        cyc(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'hEEEE, 5'd0, 5'd0);
        chk("lit_x0_alu", RegWrite, 1'b0);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        chk("lit_x0_ld", {RegWrite, ld_ready}, 2'b01);

        random_cycles(300);

        // Asynchronous reset mid-operation.
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_RegWrite", RegWrite, 1'b0);
        chk("midrst_ld_ready", ld_ready, 1'b1);
        model_reset();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        random_cycles(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
